// File: rtl/qsfp_seq_pkg.sv
// qsfp_seq_pkg: shared state encoding and width constants for the QSFP sideband sequencer
package qsfp_seq_pkg;

    localparam int MAX_CH  = 8;
    localparam int SCAN_W  = 16;
    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        RST_DLY,
        IDLE,
        PWR_START,
        PWR_WAIT,
        CH_START,
        CH_WAIT,
        CH_NEXT,
        DELAY
    } state_t;

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that saturates at zero and flags when empty
module seq_timer
    import qsfp_seq_pkg::*;
#(
    parameter logic [TIMER_W-1:0] RST_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               zero
);

    logic [TIMER_W-1:0] cnt;

    // Load has priority; otherwise count down and hold at zero
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;

    assign zero = cnt == '0;

endmodule

// File: rtl/qsfp_sb_sequencer.sv
// qsfp_sb_sequencer: powers up, then walks enabled QSFP channels in init and periodic scan passes
module qsfp_sb_sequencer
    import qsfp_seq_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned STARTUP_DLY   = 50000000,
    parameter int unsigned SCAN_PERIOD   = 50000000,
    parameter int unsigned CMPLT_TIMEOUT = 1000000,
    parameter string       SIMULATION    = "false"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_enable,
    output logic              pwr_start,
    input  logic              pwr_cmplt,
    output logic [NUM_CH-1:0] qsfp_start,
    output logic [NUM_CH-1:0] qsfp_init,
    input  logic [NUM_CH-1:0] qsfp_cmplt,
    output logic              busy,
    output logic [2:0]        cur_ch,
    output logic [NUM_CH:0]   timeout_err,
    output logic [SCAN_W-1:0] scan_count
);

    localparam bit SIM_STOP = SIMULATION == "true";
    localparam bit TMO_EN   = CMPLT_TIMEOUT != 0;

    state_t              state, state_n;
    logic                init_phase, ch_none, found, tmo;
    logic                tmr_load, tmr_zero, set_none, sel, end_pass;
    logic [2:0]          ch, nxt_ch;
    logic [TIMER_W-1:0]  tmr_val;
    logic [MAX_CH-1:0]   en_w, cmplt_w, oh;
    logic [NUM_CH:0]     err_set;

    assign en_w    = MAX_CH'(ch_enable);
    assign cmplt_w = MAX_CH'(qsfp_cmplt);
    assign oh      = MAX_CH'(1) << ch;
    assign tmo     = tmr_zero && TMO_EN;

    seq_timer #(.RST_VAL(TIMER_W'(STARTUP_DLY))) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Lowest enabled channel above the current one (any enabled channel when unstarted)
    always_comb begin
        found  = 1'b0;
        nxt_ch = '0;
        for (int i = MAX_CH - 1; i >= 0; i--)
            if (en_w[i] && (ch_none || 3'(i) > ch)) begin
                found  = 1'b1;
                nxt_ch = 3'(i);
            end
    end

    // Next state, timer loads and register update strobes
    always_comb begin
        state_n  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        set_none = 1'b0;
        sel      = 1'b0;
        end_pass = 1'b0;
        err_set  = '0;
        case (state)
            RST_DLY:   state_n = tmr_zero ? IDLE : RST_DLY;
            IDLE:      state_n = PWR_START;
            PWR_START: begin
                state_n  = PWR_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TIMER_W'(CMPLT_TIMEOUT);
                set_none = 1'b1;
            end
            PWR_WAIT: if (pwr_cmplt || tmo) begin
                state_n = CH_NEXT;
                err_set = pwr_cmplt ? '0 : (NUM_CH + 1)'(1) << NUM_CH;
            end
            CH_START: begin
                state_n  = CH_WAIT;
                tmr_load = 1'b1;
                tmr_val  = TIMER_W'(CMPLT_TIMEOUT);
            end
            CH_WAIT: if (cmplt_w[ch] || tmo) begin
                state_n = CH_NEXT;
                err_set = cmplt_w[ch] ? '0 : (NUM_CH + 1)'(oh);
            end
            CH_NEXT: begin
                state_n  = found ? CH_START : DELAY;
                sel      = found;
                end_pass = !found;
                tmr_load = !found;
                tmr_val  = TIMER_W'(SCAN_PERIOD);
            end
            DELAY: if (tmr_zero && !SIM_STOP) begin
                state_n  = CH_NEXT;
                set_none = 1'b1;
            end
            default:   state_n = RST_DLY;
        endcase
    end

    // State, channel pointer, phase flag, sticky errors and pass counter
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= RST_DLY;
            ch          <= '0;
            ch_none     <= 1'b0;
            init_phase  <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= '0;
            scan_count  <= '0;
        end else begin
            state       <= state_n;
            busy        <= !(state_n inside {IDLE, DELAY});
            timeout_err <= timeout_err | err_set;
            if (set_none) begin
                ch      <= '0;
                ch_none <= 1'b1;
            end else if (sel) begin
                ch      <= nxt_ch;
                ch_none <= 1'b0;
            end
            if (end_pass) begin
                init_phase <= 1'b0;
                scan_count <= scan_count + 1'b1;
            end
        end

    assign pwr_start  = state == PWR_START;
    assign qsfp_start = state == CH_START ? oh[NUM_CH-1:0] : '0;
    assign qsfp_init  = init_phase ? qsfp_start : '0;
    assign cur_ch     = ch;

endmodule

// File: tb/tb_qsfp_sb_sequencer.sv
// tb_qsfp_sb_sequencer: directed and randomized passes checked against a pass-level model
module tb_qsfp_sb_sequencer;

    localparam int N       = 4;
    localparam int STARTUP = 10;
    localparam int SCAN    = 20;
    localparam int TMO     = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  ch_enable = '1;
    logic          pwr_start, pwr_cmplt;
    logic [N-1:0]  qsfp_start, qsfp_init, qsfp_cmplt;
    logic          busy;
    logic [2:0]    cur_ch;
    logic [N:0]    timeout_err;
    logic [15:0]   scan_count;

    logic [N-1:0]  resp, spur = '0;
    logic          pwr_resp;
    logic [N:0]    fire;
    int            dly [N];
    int            pdly = 5;
    int            cd [N+1];
    int            mon_idx;
    int            pwr_seen = 0;
    int            tests = 0, fails = 0;

    typedef struct {int ch; bit init; bit onehot;} start_t;
    start_t seen [$];

    assign qsfp_cmplt = resp | spur;
    assign pwr_cmplt  = pwr_resp;

    always #5 clk = ~clk;

    qsfp_sb_sequencer #(
        .NUM_CH        (N),
        .STARTUP_DLY   (STARTUP),
        .SCAN_PERIOD   (SCAN),
        .CMPLT_TIMEOUT (TMO),
        .SIMULATION    ("false")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_enable   (ch_enable),
        .pwr_start   (pwr_start),
        .pwr_cmplt   (pwr_cmplt),
        .qsfp_start  (qsfp_start),
        .qsfp_init   (qsfp_init),
        .qsfp_cmplt  (qsfp_cmplt),
        .busy        (busy),
        .cur_ch      (cur_ch),
        .timeout_err (timeout_err),
        .scan_count  (scan_count)
    );

    // Responder: answers each start with a one-cycle completion after its delay (0 = never)
    always @(negedge clk) begin
        fire = '0;
        for (int i = 0; i <= N; i++)
            if (cd[i] > 0) begin
                cd[i] = cd[i] - 1;
                fire[i] = cd[i] == 0;
            end
        resp     = fire[N-1:0];
        pwr_resp = fire[N];
        for (int i = 0; i < N; i++)
            if (qsfp_start[i] && dly[i] != 0) cd[i] = dly[i];
        if (pwr_start) cd[N] = pdly;
    end

    // Monitor: records every channel start and counts power starts
    always @(negedge clk) begin
        if (|qsfp_start) begin
            mon_idx = 0;
            for (int i = 0; i < N; i++) if (qsfp_start[i]) mon_idx = i;
            seen.push_back('{mon_idx, qsfp_init[mon_idx],
                             $onehot(qsfp_start) && ((qsfp_init & ~qsfp_start) == '0)});
        end
        if (pwr_start) pwr_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scan(input logic [15:0] target, input string tag);
        int n = 0;
        while (scan_count !== target && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(scan_count), 32'(target));
    endtask

    task automatic wait_start(input int i, output int n);
        n = 0;
        while (qsfp_start[i] !== 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("start%0d seen", i), 32'(qsfp_start[i]), 1);
    endtask

    // Model: a pass starts every enabled channel once, lowest index first
    task automatic check_pass(input logic [N-1:0] en, input bit init, input string tag);
        int exp_q [$];
        for (int i = 0; i < N; i++) if (en[i]) exp_q.push_back(i);
        chk({tag, " count"}, seen.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < seen.size(); k++) begin
            chk($sformatf("%s ch[%0d]", tag, k), seen[k].ch, exp_q[k]);
            chk($sformatf("%s init[%0d]", tag, k), 32'(seen[k].init), 32'(init));
            chk($sformatf("%s onehot[%0d]", tag, k), 32'(seen[k].onehot), 1);
        end
        seen.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " pwr_start"}, 32'(pwr_start), 0);
        chk({tag, " qsfp_start"}, 32'(qsfp_start), 0);
        chk({tag, " qsfp_init"}, 32'(qsfp_init), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " cur_ch"}, 32'(cur_ch), 0);
        chk({tag, " timeout_err"}, 32'(timeout_err), 0);
        chk({tag, " scan_count"}, 32'(scan_count), 0);
    endtask

    initial begin
        int n, k;
        logic [N-1:0] en;
        logic [N:0]   err_exp;
        logic [15:0]  sc;

        for (int i = 0; i < N; i++) dly[i] = 5;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");

        rst = 1'b0;
        n = 0;
        while (!pwr_start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pwr_start latency", n, STARTUP + 2);
        chk("busy after start", 32'(busy), 1);

        wait_scan(1, "init pass end");
        check_pass(4'b1111, 1'b1, "init");
        chk("pwr_start count", pwr_seen, 1);
        chk("no errors init", 32'(timeout_err), 0);

        wait_scan(2, "scan1 end");
        check_pass(4'b1111, 1'b0, "scan1");
        chk("pwr_start once", pwr_seen, 1);

        ch_enable = 4'b1010;
        wait_scan(3, "en1010 end");
        check_pass(4'b1010, 1'b0, "en1010");

        ch_enable = 4'b1111;
        wait_start(1, n);
        ch_enable = 4'b1010;
        wait_scan(4, "midpass end");
        check_pass(4'b1011, 1'b0, "midpass");

        ch_enable = 4'b1111;
        dly[2] = 0;
        wait_start(2, n);
        k = 0;
        while (!timeout_err[2] && k < 300) begin
            @(posedge clk);
            #1;
            k++;
            spur = k == 10 ? 4'b0001 : 4'b0000;
            if (k == 20) begin
                chk("ignore cmplt cur_ch", 32'(cur_ch), 2);
                chk("ignore cmplt busy", 32'(busy), 1);
                chk("ignore cmplt no start", 32'(qsfp_start), 0);
            end
        end
        spur = '0;
        chk("timeout latency", k, TMO + 2);
        chk("timeout_err ch2", 32'(timeout_err), 32'(5'b00100));
        wait_start(3, n);
        chk("ch3 after timeout", n, 1);
        wait_scan(5, "timeout pass end");
        check_pass(4'b1111, 1'b0, "timeout pass");
        dly[2] = 5;
        wait_scan(6, "after timeout end");
        check_pass(4'b1111, 1'b0, "after timeout");
        chk("timeout_err sticky", 32'(timeout_err), 32'(5'b00100));

        err_exp = 5'b00100;
        sc = 6;
        for (int r = 0; r < 8; r++) begin
            en = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                dly[i] = $urandom_range(0, 7) == 0 ? 0 : int'($urandom_range(1, 8));
                if (en[i] && dly[i] == 0) err_exp[i] = 1'b1;
            end
            ch_enable = en;
            sc++;
            wait_scan(sc, $sformatf("rand%0d end", r));
            check_pass(en, 1'b0, $sformatf("rand%0d", r));
            chk($sformatf("rand%0d timeout_err", r), 32'(timeout_err), 32'(err_exp));
        end
        for (int i = 0; i < N; i++) dly[i] = 5;

        ch_enable = '0;
        sc++;
        wait_scan(sc, "empty pass end");
        check_pass('0, 1'b0, "empty1");
        n = 0;
        while (scan_count !== sc + 16'd1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("empty pass period", n, SCAN + 2);
        check_pass('0, 1'b0, "empty2");

        ch_enable = 4'b1111;
        wait_start(1, n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midpass rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen.delete();
        n = 0;
        while (!pwr_start && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("restart pwr latency", n, STARTUP + 2);
        chk("no starts after rst", seen.size(), 0);
        wait_start(0, n);
        chk("init restored", 32'(qsfp_init), 32'(4'b0001));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
